// File: rtl/top_alu_seq.sv
// Board ALU top: debounced push-buttons load A, B and OP in order, then one EXEC
// cycle registers the ALU result and flags onto the LEDs with a one-cycle valid strobe.
module top_alu_seq #(
    parameter int unsigned N_BITS     = 8,
    parameter int unsigned N_OP       = 6,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_BITS-1:0] i_SWs,
    input  logic [2:0]        i_buttons,
    output logic [N_BITS-1:0] o_led,
    output logic [3:0]        o_flags,
    output logic              o_valid,
    output logic [1:0]        o_state
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
    localparam int unsigned N_BTN = 3;
    localparam int unsigned MSB   = N_BITS - 1;

    localparam logic [N_OP-1:0] OP_ADD = N_OP'(6'b100000);
    localparam logic [N_OP-1:0] OP_SUB = N_OP'(6'b100010);
    localparam logic [N_OP-1:0] OP_AND = N_OP'(6'b100100);
    localparam logic [N_OP-1:0] OP_OR  = N_OP'(6'b100101);
    localparam logic [N_OP-1:0] OP_XOR = N_OP'(6'b100110);
    localparam logic [N_OP-1:0] OP_NOR = N_OP'(6'b100111);
    localparam logic [N_OP-1:0] OP_SRA = N_OP'(6'b000011);
    localparam logic [N_OP-1:0] OP_SRL = N_OP'(6'b000010);

    typedef enum logic [1:0] {
        WAIT_A  = 2'b00,
        WAIT_B  = 2'b01,
        WAIT_OP = 2'b10,
        EXEC    = 2'b11
    } state_t;

    state_t            state_q;
    logic [N_BITS-1:0] reg_a_q;
    logic [N_BITS-1:0] reg_b_q;
    logic [N_OP-1:0]   reg_op_q;

    logic [N_BTN-1:0]  sync1_q;
    logic [N_BTN-1:0]  sync2_q;
    logic [N_BTN-1:0]  deb_q;
    logic [N_BTN-1:0]  deb_d_q;
    logic [N_BTN-1:0]  press_q;
    logic [CNT_W-1:0]  cnt_q [N_BTN];

    logic              single_press_c;
    logic [N_BITS:0]   wide_c;
    logic [N_BITS-1:0] alu_res_c;
    logic              alu_err_c;
    logic              alu_ovf_c;
    logic              alu_carry_c;

    // Synchronise, debounce and edge-detect each button; press_q is a registered 1-cycle pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            deb_d_q <= '0;
            press_q <= '0;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= i_buttons;
            sync2_q <= sync1_q;
            deb_d_q <= deb_q;
            press_q <= deb_q & ~deb_d_q;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_W'(DEB_CYCLES - 1)) begin
                    deb_q[i] <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Simultaneous presses are discarded as a whole.
    assign single_press_c = (press_q != '0) && ((press_q & (press_q - 3'd1)) == '0);

    // ALU stage; shift amount is the full unsigned B.
    always_comb begin
        wide_c      = '0;
        alu_res_c   = '0;
        alu_err_c   = 1'b0;
        alu_ovf_c   = 1'b0;
        alu_carry_c = 1'b0;
        case (reg_op_q)
            OP_ADD: begin
                wide_c      = {1'b0, reg_a_q} + {1'b0, reg_b_q};
                alu_res_c   = wide_c[N_BITS-1:0];
                alu_carry_c = wide_c[N_BITS];
                alu_ovf_c   = (reg_a_q[MSB] == reg_b_q[MSB]) && (alu_res_c[MSB] != reg_a_q[MSB]);
            end
            OP_SUB: begin
                wide_c      = {1'b0, reg_a_q} - {1'b0, reg_b_q};
                alu_res_c   = wide_c[N_BITS-1:0];
                alu_carry_c = wide_c[N_BITS];
                alu_ovf_c   = (reg_a_q[MSB] != reg_b_q[MSB]) && (alu_res_c[MSB] != reg_a_q[MSB]);
            end
            OP_AND: alu_res_c = reg_a_q & reg_b_q;
            OP_OR:  alu_res_c = reg_a_q | reg_b_q;
            OP_XOR: alu_res_c = reg_a_q ^ reg_b_q;
            OP_NOR: alu_res_c = ~(reg_a_q | reg_b_q);
            OP_SRA: begin
                if (reg_b_q >= N_BITS'(N_BITS)) begin
                    alu_res_c = {N_BITS{reg_a_q[MSB]}};
                end else begin
                    alu_res_c = N_BITS'($signed(reg_a_q) >>> reg_b_q);
                end
            end
            OP_SRL: begin
                if (reg_b_q >= N_BITS'(N_BITS)) begin
                    alu_res_c = '0;
                end else begin
                    alu_res_c = reg_a_q >> reg_b_q;
                end
            end
            default: alu_err_c = 1'b1;
        endcase
    end

    // Load sequencer with registered result, flags and valid strobe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= WAIT_A;
            reg_a_q  <= '0;
            reg_b_q  <= '0;
            reg_op_q <= '0;
            o_led    <= '0;
            o_flags  <= '0;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state_q)
                WAIT_A: begin
                    if (single_press_c && press_q[2]) begin
                        reg_a_q <= i_SWs;
                        state_q <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (single_press_c && press_q[1]) begin
                        reg_b_q <= i_SWs;
                        state_q <= WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (single_press_c && press_q[0]) begin
                        reg_op_q <= i_SWs[N_OP-1:0];
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    o_led   <= alu_res_c;
                    o_flags <= {alu_err_c, alu_ovf_c, alu_carry_c, (alu_res_c == '0)};
                    o_valid <= 1'b1;
                    state_q <= WAIT_A;
                end
                default: state_q <= WAIT_A;
            endcase
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_top_alu_seq.sv
// Bench for top_alu_seq: directed button sequences with a queue scoreboard checked
// by an independent monitor whenever o_valid is seen.
module tb_top_alu_seq;

    logic       clock;
    logic       reset;
    logic [7:0] i_SWs;
    logic [2:0] i_buttons;
    logic [7:0] o_led;
    logic [3:0] o_flags;
    logic       o_valid;
    logic [1:0] o_state;

    int checks = 0;
    int errors = 0;
    logic [11:0] sb [$];

    top_alu_seq #(
        .N_BITS    (8),
        .N_OP      (6),
        .DEB_CYCLES(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .i_SWs    (i_SWs),
        .i_buttons(i_buttons),
        .o_led    (o_led),
        .o_flags  (o_flags),
        .o_valid  (o_valid),
        .o_state  (o_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every valid strobe must match the oldest expected result.
    always @(negedge clock) begin
        if (reset && o_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL valid_unexpected: got led=0x%0h flags=%b with nothing expected", o_led, o_flags);
            end else begin
                chk("scoreboard_led_flags", {20'd0, o_led, o_flags}, {20'd0, sb.pop_front()});
            end
        end
    end

    task automatic press(input int idx, input logic [7:0] sws, input int len);
        @(negedge clock);
        i_SWs = sws;
        i_buttons[idx] = 1'b1;
        repeat (len) @(negedge clock);
        i_buttons = 3'b000;
        repeat (12) @(negedge clock);
    endtask

    // Button first sampled at edge k; state checked just after edges k+6 and k+7.
    task automatic press_timed(input int idx, input logic [7:0] sws, input logic [1:0] st_before,
                               input logic [1:0] st_after, input string name);
        @(negedge clock);
        i_SWs = sws;
        i_buttons[idx] = 1'b1;
        repeat (7) @(negedge clock);
        chk({name, "_state_k6"}, 32'(o_state), 32'(st_before));
        @(negedge clock);
        chk({name, "_state_k7"}, 32'(o_state), 32'(st_after));
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input logic [7:0] exp_led, input logic [3:0] exp_flags, input string name);
        sb.push_back({exp_led, exp_flags});
        press(2, a, 5);
        press(1, b, 5);
        press(0, op, 5);
        chk({name, "_result_seen"}, 32'(sb.size()), 32'd0);
        chk({name, "_state_idle"}, 32'(o_state), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        i_SWs     = 8'h00;
        i_buttons = 3'b000;
        repeat (3) @(negedge clock);
        chk("reset_led", 32'(o_led), 32'd0);
        chk("reset_flags", 32'(o_flags), 32'd0);
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_state", 32'(o_state), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Short glitch on the A button must not load.
        press(2, 8'h55, 3);
        chk("glitch_state", 32'(o_state), 32'd0);

        // ADD with exact load and valid timing.
        press_timed(2, 8'h7F, 2'b00, 2'b01, "loadA");
        i_buttons = 3'b000;
        repeat (12) @(negedge clock);
        press(1, 8'h01, 5);
        chk("wait_op_state", 32'(o_state), 32'd2);
        sb.push_back({8'h80, 4'b0100});
        press_timed(0, 8'h20, 2'b10, 2'b11, "loadOP");
        chk("exec_valid_low", 32'(o_valid), 32'd0);
        @(negedge clock);
        chk("add_valid_pulse", 32'(o_valid), 32'd1);
        chk("add_led", 32'(o_led), 32'h80);
        chk("add_flags", 32'(o_flags), 32'b0100);
        chk("add_back_to_wait_a", 32'(o_state), 32'd0);
        @(negedge clock);
        chk("add_valid_one_cycle", 32'(o_valid), 32'd0);
        chk("add_led_hold", 32'(o_led), 32'h80);
        i_buttons = 3'b000;
        repeat (12) @(negedge clock);

        run_op(8'h05, 8'h05, 8'h22, 8'h00, 4'b0001, "sub_equal");
        run_op(8'h03, 8'h05, 8'h22, 8'hFE, 4'b0010, "sub_borrow");
        run_op(8'h80, 8'h01, 8'h22, 8'h7F, 4'b0100, "sub_ovf");
        run_op(8'hFF, 8'h01, 8'h20, 8'h00, 4'b0011, "add_carry");
        run_op(8'h80, 8'h03, 8'h03, 8'hF0, 4'b0000, "sra3");
        run_op(8'h80, 8'h09, 8'h03, 8'hFF, 4'b0000, "sra_big");
        run_op(8'h80, 8'h09, 8'h02, 8'h00, 4'b0001, "srl_big");
        run_op(8'hF0, 8'h02, 8'h02, 8'h3C, 4'b0000, "srl2");
        run_op(8'h0F, 8'h3C, 8'h24, 8'h0C, 4'b0000, "and");
        run_op(8'h0F, 8'hF0, 8'h27, 8'h00, 4'b0001, "nor");
        run_op(8'h12, 8'h34, 8'h3F, 8'h00, 4'b1001, "bad_op");

        // Out-of-order and simultaneous presses are ignored.
        press(1, 8'h11, 5);
        chk("wrong_button_ignored", 32'(o_state), 32'd0);
        @(negedge clock);
        i_SWs = 8'h22;
        i_buttons = 3'b110;
        repeat (5) @(negedge clock);
        i_buttons = 3'b000;
        repeat (12) @(negedge clock);
        chk("simultaneous_ignored", 32'(o_state), 32'd0);
        sb.push_back({8'hEE, 4'b0000});
        press(2, 8'hCC, 5);
        chk("single_press_accepted", 32'(o_state), 32'd1);
        press(1, 8'hAA, 5);
        press(0, 8'h25, 5);
        chk("or_result_seen", 32'(sb.size()), 32'd0);

        // Asynchronous reset mid-sequence.
        run_op(8'h7F, 8'h01, 8'h20, 8'h80, 4'b0100, "add_again");
        press(2, 8'h01, 5);
        press(1, 8'h02, 5);
        chk("pre_reset_state", 32'(o_state), 32'd2);
        chk("pre_reset_led", 32'(o_led), 32'h80);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset_led", 32'(o_led), 32'd0);
        chk("async_reset_flags", 32'(o_flags), 32'd0);
        chk("async_reset_valid", 32'(o_valid), 32'd0);
        chk("async_reset_state", 32'(o_state), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        run_op(8'hFF, 8'h0F, 8'h26, 8'hF0, 4'b0000, "xor_after_reset");

        repeat (5) @(negedge clock);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
